// File: rtl/bp_pkg.sv
// Shared types and constants for the bimodal/gshare branch predictor.
// Counter encoding and BTB entry layout live here so every file agrees on them.
package bp_pkg;

  localparam int unsigned PC_W_DEF  = 5;
  localparam int unsigned IDX_W_DEF = 3;

  typedef logic [1:0] counter_t;

  localparam counter_t SNT = 2'b00;
  localparam counter_t WNT = 2'b01;
  localparam counter_t WT  = 2'b10;
  localparam counter_t ST  = 2'b11;

  typedef struct packed {
    logic                            valid;
    logic [PC_W_DEF-IDX_W_DEF-1:0]   tag;
    logic [PC_W_DEF-1:0]             target;
  } btb_entry_t;

endpackage

// File: rtl/branch_predictor_unit_if.sv
// Fetch/execute connection between the pipeline and the branch predictor.
// master = pipeline side, slave = predictor side.
interface branch_predictor_unit_if #(
  parameter int unsigned PC_W = 5
);
  logic [PC_W-1:0] PC_F;
  logic            prediction_F;
  logic [PC_W-1:0] target_F;
  logic            update_signal_E;
  logic [PC_W-1:0] PC_E;
  logic            actual_outcome_E;
  logic [PC_W-1:0] actual_target_E;
  logic            prediction_E;
  logic            mispredict_E;

  modport master (
    output PC_F, update_signal_E, PC_E, actual_outcome_E, actual_target_E, prediction_E,
    input  prediction_F, target_F, mispredict_E
  );

  modport slave (
    input  PC_F, update_signal_E, PC_E, actual_outcome_E, actual_target_E, prediction_E,
    output prediction_F, target_F, mispredict_E
  );
endinterface

// File: rtl/bp_sat_counter.sv
// 2-bit saturating up/down counter step (combinational next value).
module bp_sat_counter
  import bp_pkg::*;
(
  input  counter_t cnt,
  input  logic     up,
  output counter_t next
);
  always_comb begin
    next = cnt;
    if (up) begin
      if (cnt != ST) next = cnt + 2'd1;
    end else begin
      if (cnt != SNT) next = cnt - 2'd1;
    end
  end
endmodule

// File: rtl/branch_predictor_unit.sv
// Bimodal branch predictor with direct-mapped BTB and saturating statistics.
// Define GSHARE_EN to XOR a global history register into the PHT index.
module branch_predictor_unit
  import bp_pkg::*;
#(
  parameter int unsigned PC_W  = PC_W_DEF,
  parameter int unsigned IDX_W = IDX_W_DEF,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  branch_predictor_unit_if.slave     bp,
  output logic [CNT_W-1:0]           branch_cnt,
  output logic [CNT_W-1:0]           mispredict_cnt
);
  localparam int unsigned ENTRIES = 1 << IDX_W;

  counter_t         pht_q [ENTRIES];
  btb_entry_t       btb_q [ENTRIES];
  logic [CNT_W-1:0] branch_cnt_q, mispredict_cnt_q;

  logic [IDX_W-1:0] fetch_idx, fetch_pidx, upd_idx, upd_pidx;
  logic             hit;
  counter_t         pht_next;

  assign fetch_idx = bp.PC_F[IDX_W-1:0];
  assign upd_idx   = bp.PC_E[IDX_W-1:0];

`ifdef GSHARE_EN
  logic [IDX_W-1:0] ghr_q;
  // Both lookup and update hash with the pre-shift history.
  assign fetch_pidx = fetch_idx ^ ghr_q;
  assign upd_pidx   = upd_idx ^ ghr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q <= '0;
    end else if (bp.update_signal_E) begin
      ghr_q <= {ghr_q[IDX_W-2:0], bp.actual_outcome_E};
    end
  end
`else
  assign fetch_pidx = fetch_idx;
  assign upd_pidx   = upd_idx;
`endif

  always_comb begin
    hit             = btb_q[fetch_idx].valid && (btb_q[fetch_idx].tag == bp.PC_F[PC_W-1:IDX_W]);
    bp.prediction_F = !reset && hit && (pht_q[fetch_pidx] >= WT);
    bp.target_F     = bp.prediction_F ? btb_q[fetch_idx].target : bp.PC_F + PC_W'(1);
    bp.mispredict_E = bp.update_signal_E && (bp.prediction_E != bp.actual_outcome_E);
  end

  bp_sat_counter u_pht_step (
    .cnt  (pht_q[upd_pidx]),
    .up   (bp.actual_outcome_E),
    .next (pht_next)
  );

  // Reset has priority, so an update coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        pht_q[i] <= WNT;
        btb_q[i] <= '0;
      end
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (bp.update_signal_E) begin
      pht_q[upd_pidx] <= pht_next;
      if (bp.actual_outcome_E) begin
        btb_q[upd_idx] <= '{valid: 1'b1, tag: bp.PC_E[PC_W-1:IDX_W],
                            target: bp.actual_target_E};
      end
      if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + CNT_W'(1);
      if (bp.mispredict_E && (mispredict_cnt_q != '1)) begin
        mispredict_cnt_q <= mispredict_cnt_q + CNT_W'(1);
      end
    end
  end

  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Self-checking bench: directed literal cases plus random traffic against a behavioural model.
module tb_branch_predictor_unit;
  localparam int PCW  = 5;
  localparam int IDXW = 3;
  localparam int CNTW = 6;
  localparam int N    = 8;
  localparam int PCM  = 32;
  localparam int MAXC = 63;

  logic clk = 1'b0;
  logic reset;
  logic [CNTW-1:0] branch_cnt, mispredict_cnt;

  branch_predictor_unit_if #(.PC_W(PCW)) bus ();

  branch_predictor_unit #(.PC_W(PCW), .IDX_W(IDXW), .CNT_W(CNTW)) dut (
    .clk            (clk),
    .reset          (reset),
    .bp             (bus.slave),
    .branch_cnt     (branch_cnt),
    .mispredict_cnt (mispredict_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain integer arrays indexed by table slot.
  int  m_pht [N];
  bit  m_v   [N];
  int  m_tag [N];
  int  m_tgt [N];
  int  m_ghr, m_bc, m_mc;
  bit  model_ok = 0;

  function automatic int pht_index(input int pc);
`ifdef GSHARE_EN
    return (pc % N) ^ m_ghr;
`else
    return pc % N;
`endif
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        for (int i = 0; i < N; i++) begin
          m_pht[i] = 1; m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0;
        end
        m_ghr = 0; m_bc = 0; m_mc = 0;
        model_ok = 1;
      end else if (model_ok && bus.update_signal_E) begin
        int pce, out, e, pe;
        pce = int'(bus.PC_E);
        out = int'(bus.actual_outcome_E);
        e   = pce % N;
        pe  = pht_index(pce);
        if (out == 1) m_pht[pe] = (m_pht[pe] == 3) ? 3 : m_pht[pe] + 1;
        else          m_pht[pe] = (m_pht[pe] == 0) ? 0 : m_pht[pe] - 1;
        if (out == 1) begin
          m_v[e] = 1; m_tag[e] = pce / N; m_tgt[e] = int'(bus.actual_target_E);
        end
        m_ghr = ((m_ghr * 2) + out) % N;
        if (m_bc < MAXC) m_bc++;
        if ((bus.prediction_E != bus.actual_outcome_E) && m_mc < MAXC) m_mc++;
      end
    end
  end

  // Compare process: inputs settle at posedge+1, outputs checked at negedge.
  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        int pcf, idx, pred, tgt, misp;
        pcf  = int'(bus.PC_F);
        idx  = pcf % N;
        pred = (!reset && m_v[idx] && m_tag[idx] == pcf / N && m_pht[pht_index(pcf)] >= 2) ? 1 : 0;
        tgt  = (pred == 1) ? m_tgt[idx] : (pcf + 1) % PCM;
        misp = (bus.update_signal_E && bus.prediction_E != bus.actual_outcome_E) ? 1 : 0;
        check("model prediction_F", 32'(bus.prediction_F), 32'(pred));
        check("model target_F", 32'(bus.target_F), 32'(tgt));
        check("model mispredict_E", 32'(bus.mispredict_E), 32'(misp));
        check("model branch_cnt", 32'(branch_cnt), 32'(m_bc));
        check("model mispredict_cnt", 32'(mispredict_cnt), 32'(m_mc));
      end
    end
  end

  task automatic drive(input bit rst, input int pcf, input bit upd, input int pce,
                       input bit out, input int tgt, input bit prede);
    reset                = rst;
    bus.PC_F             = PCW'(pcf);
    bus.update_signal_E  = upd;
    bus.PC_E             = PCW'(pce);
    bus.actual_outcome_E = out;
    bus.actual_target_E  = PCW'(tgt);
    bus.prediction_E     = prede;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic update(input int pce, input bit out, input int tgt);
    drive(0, 0, 1, pce, out, tgt, 0);
    tick();
  endtask

  task automatic lookup(input string name, input int pcf, input int pred, input int tgt);
    drive(0, pcf, 0, 0, 0, 0, 0);
    check({name, " prediction_F"}, 32'(bus.prediction_F), 32'(pred));
    check({name, " target_F"}, 32'(bus.target_F), 32'(tgt));
  endtask

  initial begin
    drive(1, 4, 0, 0, 0, 0, 0);
    tick();
    drive(1, 4, 0, 0, 0, 0, 0);
    check("under reset prediction_F", 32'(bus.prediction_F), 32'd0);
    check("under reset target_F", 32'(bus.target_F), 32'd5);
    tick();

`ifndef GSHARE_EN
    lookup("reset lookup", 4, 0, 5);
    check("reset branch_cnt", 32'(branch_cnt), 32'd0);

    drive(0, 0, 1, 4, 1, 12, 0);
    check("update mispredict_E", 32'(bus.mispredict_E), 32'd1);
    tick();
    lookup("after 1st taken", 4, 1, 12);
    update(4, 1, 12);
    lookup("after 2nd taken", 4, 1, 12);

    update(4, 0, 0);
    lookup("ST->WT", 4, 1, 12);
    update(4, 0, 0);
    lookup("WT->WNT", 4, 0, 5);
    update(4, 0, 0);
    update(4, 0, 0);
    update(4, 1, 12);
    lookup("SNT saturated then +1", 4, 0, 5);
    check("branch_cnt after 7", 32'(branch_cnt), 32'd7);
    check("mispredict_cnt after 7", 32'(mispredict_cnt), 32'd3);

    update(12, 1, 20);
    lookup("alias PC 4 misses", 4, 0, 5);
    lookup("alias PC 12 hits", 12, 1, 20);

    drive(0, 2, 1, 2, 1, 9, 0);
    check("same-cycle prediction_F", 32'(bus.prediction_F), 32'd0);
    check("same-cycle target_F", 32'(bus.target_F), 32'd3);
    tick();
    lookup("next-cycle", 2, 1, 9);

    drive(1, 2, 1, 6, 1, 9, 0);
    tick();
    lookup("reset-with-update cleared", 2, 0, 3);
    check("reset-with-update branch_cnt", 32'(branch_cnt), 32'd0);
    check("reset-with-update mispredict_cnt", 32'(mispredict_cnt), 32'd0);
    update(2, 1, 9);
    lookup("PHT back at WNT", 2, 1, 9);
`else
    update(0, 1, 6);
    update(0, 1, 6);
    update(0, 1, 6);
    lookup("gshare PC0 uses index 7", 0, 0, 1);
`endif

    for (int i = 0; i < 1500; i++) begin
      drive((i < 900) && ($urandom_range(0, 63) == 0), $urandom_range(0, PCM - 1),
            $urandom_range(0, 3) != 0, $urandom_range(0, PCM - 1), 1'($urandom),
            $urandom_range(0, PCM - 1), 1'($urandom));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    check("branch_cnt saturated", 32'(branch_cnt), 32'(MAXC));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
